// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared state encoding, word type and depth default for accum_loader
package accum_pkg;
    localparam int DEPTH_DEFAULT = 1000;

    typedef logic signed [63:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_KICK,
        ST_WAIT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/accum_addr_ctr.sv
// rtl/accum_addr_ctr.sv - array address counter with clear, increment and terminal flag at DEPTH-1
module accum_addr_ctr #(
    parameter int DEPTH = 1000,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [AW:0] count,
    output logic        term
);
    localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    // Saturates at DEPTH so the count can report a full array but never run past it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == LAST);
endmodule

// File: rtl/accum_loader.sv
// rtl/accum_loader.sv - streams words into a downstream array, kicks it and reports its result (ACCUM_LOADER_ZEROFILL_EN adds zero-fill)
module accum_loader
    import accum_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      cfg_init_i,
    input  logic signed [63:0] cfg_init_acc,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [63:0] in_data,
    input  logic               in_last,
    output logic               controlArr,
    output logic               controlArrWEnable_a,
    output logic [AW-1:0]      controlArrAddr_a,
    output logic [63:0]        controlArrWData_a,
    input  logic [63:0]        controlArrRData_a,
    output logic               r_enable,
    output logic [AW-1:0]      init_i,
    output logic signed [63:0] init_acc,
    input  logic               w_enable,
    input  logic               result,
    output logic               busy,
    output logic               done_valid,
    output logic               done_result,
    output logic [AW:0]        done_count
);
    state_t      state, state_n;
    logic        ctr_clr, ctr_inc, ctr_term, load_exit;
    logic [AW:0] ctr_count, words;
    logic        unused_rdata;

    // The array is write-only from here; read data is deliberately not consumed.
    assign unused_rdata = ^controlArrRData_a;

    accum_addr_ctr #(.DEPTH(DEPTH), .AW(AW)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .inc   (ctr_inc),
        .count (ctr_count),
        .term  (ctr_term)
    );

`ifdef ACCUM_LOADER_ZEROFILL_EN
    // Fill keeps advancing the counter, so the stream length is frozen at load exit.
    logic [AW:0] stream_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stream_cnt <= '0;
        end else if (load_exit) begin
            stream_cnt <= ctr_count + 1'b1;
        end
    end

    assign words = stream_cnt;
`else
    assign words = ctr_count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            init_i      <= '0;
            init_acc    <= '0;
            done_result <= 1'b0;
            done_count  <= '0;
        end else begin
            state <= state_n;
            if ((state == ST_IDLE) && start) begin
                init_i   <= cfg_init_i;
                init_acc <= cfg_init_acc;
            end
            if ((state == ST_WAIT) && w_enable) begin
                done_result <= result;
                done_count  <= words;
            end
        end
    end

    always_comb begin
        state_n             = state;
        busy                = (state != ST_IDLE);
        in_ready            = 1'b0;
        controlArr          = 1'b0;
        controlArrWEnable_a = 1'b0;
        controlArrAddr_a    = ctr_count[AW-1:0];
        controlArrWData_a   = '0;
        r_enable            = 1'b0;
        done_valid          = 1'b0;
        ctr_clr             = 1'b0;
        ctr_inc             = 1'b0;
        load_exit           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    ctr_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                in_ready          = 1'b1;
                controlArr        = 1'b1;
                controlArrWData_a = in_data;
                if (in_valid) begin
                    controlArrWEnable_a = 1'b1;
                    ctr_inc             = 1'b1;
                    if (in_last || ctr_term) begin
                        load_exit = 1'b1;
`ifdef ACCUM_LOADER_ZEROFILL_EN
                        state_n   = ctr_term ? ST_KICK : ST_FILL;
`else
                        state_n   = ST_KICK;
`endif
                    end
                end
            end
`ifdef ACCUM_LOADER_ZEROFILL_EN
            ST_FILL: begin
                controlArr          = 1'b1;
                controlArrWEnable_a = 1'b1;
                ctr_inc             = 1'b1;
                if (ctr_term) begin
                    state_n = ST_KICK;
                end
            end
`endif
            ST_KICK: begin
                r_enable = 1'b1;
                state_n  = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_enable) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_accum_loader.sv
// tb/tb_accum_loader.sv - scoreboard bench for accum_loader: directed jobs, queued expected writes and done pulses
module tb_accum_loader;
    import accum_pkg::*;

    localparam int DEPTH = 1000;
    localparam int AW    = 10;

    logic               clk = 1'b0;
    logic               rst, start;
    logic [AW-1:0]      cfg_init_i;
    logic signed [63:0] cfg_init_acc;
    logic               in_valid, in_ready, in_last;
    logic signed [63:0] in_data;
    logic               controlArr, controlArrWEnable_a;
    logic [AW-1:0]      controlArrAddr_a;
    logic [63:0]        controlArrWData_a, controlArrRData_a;
    logic               r_enable;
    logic [AW-1:0]      init_i;
    logic signed [63:0] init_acc;
    logic               w_enable, result, busy, done_valid, done_result;
    logic [AW:0]        done_count;

    always #5 clk = ~clk;

    accum_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .cfg_init_i          (cfg_init_i),
        .cfg_init_acc        (cfg_init_acc),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .controlArr          (controlArr),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrRData_a   (controlArrRData_a),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .init_acc            (init_acc),
        .w_enable            (w_enable),
        .result              (result),
        .busy                (busy),
        .done_valid          (done_valid),
        .done_result         (done_result),
        .done_count          (done_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    wr_t           wr_q[$];
    logic [AW+1:0] done_q[$];
    wr_t           mon_w;
    logic [AW+1:0] mon_d;
    int            errors = 0;
    int            checks = 0;
    int            kick_cnt = 0;
    int            ds_delay = 0;
    logic          ds_result = 1'b0;
    int            acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every array write must match the next queued expectation.
    always @(negedge clk) begin
        if (controlArrWEnable_a) begin
            if (wr_q.size() == 0) begin
                chk("write_expected", 64'(wr_q.size()), 64'd1);
            end else begin
                mon_w = wr_q.pop_front();
                chk("write_addr", 64'(controlArrAddr_a), 64'(mon_w.addr));
                chk("write_data", controlArrWData_a, mon_w.data);
                chk("write_ctrl", 64'(controlArr), 64'd1);
            end
        end
        if (done_valid) begin
            if (done_q.size() == 0) begin
                chk("done_expected", 64'(done_q.size()), 64'd1);
            end else begin
                mon_d = done_q.pop_front();
                chk("done_count", 64'(done_count), 64'(mon_d[AW+1:1]));
                chk("done_result", 64'(done_result), 64'(mon_d[0]));
            end
        end
    end

    // Downstream model: clears w_enable on the kick, then completes after ds_delay cycles.
    initial begin
        w_enable = 1'b0;
        result   = 1'b0;
        forever begin
            @(negedge clk);
            if (r_enable) begin
                kick_cnt++;
                w_enable = 1'b0;
                chk("kick_ctrl_low", 64'(controlArr), 64'd0);
                repeat (ds_delay) @(negedge clk);
                result   = ds_result;
                w_enable = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [AW-1:0] i0, input logic [63:0] a0);
        @(posedge clk); #1;
        cfg_init_i   = i0;
        cfg_init_acc = a0;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic stream(input int n, input int last_idx, input logic [63:0] base,
                          input logic [63:0] step, input bit toggle, input int budget,
                          output int accepted);
        int   i;
        int   cyc;
        logic v;
        i   = 0;
        cyc = 0;
        while (i < n && cyc < budget) begin
            v        = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_valid = v;
            in_data  = base + 64'(i) * step;
            in_last  = (i == last_idx);
            if (v && in_ready) begin
                wr_q.push_back('{addr: AW'(i), data: in_data});
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        accepted = i;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("job_finished", 64'(busy), 64'd0);
    endtask

    task automatic wait_kick(input int budget);
        int n;
        n = 0;
        while (!r_enable && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("kick_seen", 64'(r_enable), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_init_i = '0; cfg_init_acc = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; controlArrRData_a = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outputs", 64'({in_ready, controlArr, controlArrWEnable_a, r_enable, done_valid}), 64'd0);
        chk("rst_done_regs", 64'({done_result, done_count}), 64'd0);
        rst = 1'b0;

        // Full 1000-word load terminated by in_last on the final word.
        ds_delay = 3; ds_result = 1'b1;
        do_start(AW'(0), 64'd5);
        chk("a_init_acc", init_acc, 64'd5);
        chk("a_init_i", 64'(init_i), 64'd0);
        chk("a_in_ready", 64'(in_ready), 64'd1);
        done_q.push_back({(AW+1)'(1000), 1'b1});
        stream(1000, 999, 64'd1, 64'd0, 1'b0, 1100, acc);
        chk("a_accepted", 64'(acc), 64'd1000);
        wait_idle(200);
        chk("a_kicks", 64'(kick_cnt), 64'd1);
        chk("a_done_hold", 64'({done_result, done_count}), {52'd0, 1'b1, 11'd1000});

        // 1003 words without in_last: the array bound ends the load.
        ds_delay = 2; ds_result = 1'b0;
        do_start(AW'(3), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("b_init_i", 64'(init_i), 64'd3);
        done_q.push_back({(AW+1)'(1000), 1'b0});
        stream(1003, -1, 64'd100, 64'd1, 1'b0, 1010, acc);
        chk("b_accepted", 64'(acc), 64'd1000);
        chk("b_pending", 64'(1003 - acc), 64'd3);
        chk("b_in_ready_low", 64'(in_ready), 64'd0);
        wait_idle(200);

        // Short job: in_last on the tenth word.
        ds_delay = 1; ds_result = 1'b1;
        do_start(AW'(10), 64'd0);
        done_q.push_back({(AW+1)'(10), 1'b1});
        stream(10, 9, 64'd7, 64'd3, 1'b0, 20, acc);
        chk("c_accepted", 64'(acc), 64'd10);
`ifdef ACCUM_LOADER_ZEROFILL_EN
        for (int a = 10; a < DEPTH; a++) wr_q.push_back('{addr: AW'(a), data: 64'd0});
        chk("c_fill_first", 64'({controlArr, controlArrWEnable_a, controlArrAddr_a}), {52'd0, 1'b1, 1'b1, 10'd10});
`else
        chk("c_kick_next", 64'(r_enable), 64'd1);
`endif
        wait_idle(1200);

        // Toggling in_valid, w_enable ready in the cycle right after the kick.
        ds_delay = 0; ds_result = 1'b0;
        do_start(AW'(1), 64'd100);
        done_q.push_back({(AW+1)'(8), 1'b0});
        stream(8, 7, 64'h55, 64'h11, 1'b1, 40, acc);
        chk("d_accepted", 64'(acc), 64'd8);
        wait_idle(1200);

        // start during WAIT must not disturb the latched configuration.
        ds_delay = 12; ds_result = 1'b1;
        do_start(AW'(5), 64'd77);
        done_q.push_back({(AW+1)'(4), 1'b1});
        stream(4, 3, 64'd9, 64'd1, 1'b0, 10, acc);
        wait_kick(1200);
        @(posedge clk); #1;
        cfg_init_i = AW'(2); cfg_init_acc = 64'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("e_init_acc", init_acc, 64'd77);
        chk("e_init_i", 64'(init_i), 64'd5);
        chk("e_no_load", 64'({busy, in_ready}), 64'd2);
        wait_idle(200);

        // Reset in WAIT aborts without a done pulse; rst beats start.
        ds_delay = 20; ds_result = 1'b0;
        do_start(AW'(0), 64'd11);
        stream(3, 2, 64'd40, 64'd2, 1'b0, 10, acc);
        wait_kick(1200);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("f_rst_busy", 64'(busy), 64'd0);
        chk("f_rst_outputs", 64'({in_ready, controlArr, controlArrWEnable_a, r_enable, done_valid}), 64'd0);
        chk("f_rst_done_regs", 64'({done_result, done_count}), 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("f_rst_beats_start", 64'(busy), 64'd0);
        repeat (25) @(posedge clk);
        #1;
        ds_delay = 2; ds_result = 1'b1;
        do_start(AW'(0), 64'd1);
        done_q.push_back({(AW+1)'(5), 1'b1});
        stream(5, 4, 64'd3, 64'd5, 1'b0, 10, acc);
        wait_idle(1200);
        chk("f_done_regs", 64'({done_result, done_count}), {52'd0, 1'b1, 11'd5});

        repeat (3) @(posedge clk);
        #1;
        chk("end_kicks", 64'(kick_cnt), 64'd7);
        chk("end_writes_drained", 64'(wr_q.size()), 64'd0);
        chk("end_dones_drained", 64'(done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accum_loader.md
ACCUM_LOADER -- requirements
Module: accum_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1000, meaning array word count; addresses span 0..DEPTH-1.
REQ-002 SHALL have parameter AW, default 10, meaning address width; DEPTH SHALL be at most 2**AW.
REQ-003 clk  input  1  sole clock; all logic updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load/run job; honoured only in IDLE.
REQ-006 cfg_init_i  input  AW  start index for the job; latched on an accepted start.
REQ-007 cfg_init_acc  input  64 signed  initial accumulator for the job; latched on an accepted start.
REQ-008 in_valid / in_ready / in_data[63:0] signed / in_last  input/output/input/input  load stream (valid/ready).
REQ-009 controlArr, controlArrWEnable_a, controlArrAddr_a[AW-1:0], controlArrWData_a[63:0]  output  downstream array override port.
REQ-010 controlArrRData_a  input  64  downstream array read data; unused except under REQ-030.
REQ-011 r_enable  output  1  downstream start pulse; init_i[AW-1:0] and init_acc[63:0] are outputs driven from the latched configuration.
REQ-012 w_enable, result  input  1 each  downstream completion flag and result bit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done_valid / done_result / done_count[AW:0]  output  1/1/AW+1  one-cycle job completion pulse, the captured result bit, and the number of stream words written.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, FILL, KICK, WAIT and DONE.
REQ-016 IDLE->LOAD SHALL occur on start; the address counter SHALL clear to 0 and cfg SHALL be latched.
REQ-017 LOAD: in_ready SHALL be 1 and controlArr SHALL be 1; a transfer (in_valid&&in_ready) SHALL assert controlArrWEnable_a with address = counter and data = in_data in the same cycle, and the counter SHALL increment.
REQ-018 LOAD SHALL exit after the transfer at which in_last=1 or the counter equals DEPTH-1, whichever comes first; a transfer at address DEPTH-1 SHALL end the load even when in_last=0.
REQ-019 LOAD exit SHALL go to FILL when REQ-030 applies and fewer than DEPTH words were written; otherwise it SHALL go to KICK.
REQ-020 KICK SHALL last exactly one cycle with r_enable=1 and controlArr=0; r_enable SHALL be 0 in every other state.
REQ-021 WAIT SHALL hold controlArr=0 and remain until w_enable=1; w_enable seen in the cycle after KICK is valid, because the downstream clears it on r_enable.
REQ-022 WAIT->DONE SHALL capture result; DONE SHALL last one cycle with done_valid=1 and then return to IDLE.
REQ-023 done_result and done_count SHALL hold their values until the next DONE.
REQ-024 When not in LOAD/FILL, controlArrWEnable_a SHALL be 0 and in_ready SHALL be 0.
REQ-025 start asserted while busy SHALL be ignored and SHALL NOT modify the latched cfg.
REQ-026 in_valid while not in LOAD SHALL leave the stream unconsumed.
REQ-027 The counter SHALL never exceed DEPTH, and no write SHALL target an address of DEPTH or above.

Reset
REQ-028 On rst, state SHALL become IDLE and the counter SHALL become 0.
REQ-029 On rst, the outputs SHALL be: busy=0, in_ready=0, controlArr=0, controlArrWEnable_a=0, r_enable=0, done_valid=0, done_result=0, done_count=0; rst SHALL win over start in the same cycle, and rst mid-job SHALL abort without a done pulse.

Configuration
REQ-030 With ACCUM_LOADER_ZEROFILL_EN defined, FILL SHALL write 64'd0 to each remaining address counter..DEPTH-1, one per cycle with controlArr=1, then go to KICK; done_count SHALL report stream words only.
REQ-031 Without ACCUM_LOADER_ZEROFILL_EN, FILL SHALL be absent, unwritten addresses SHALL keep their prior contents, and controlArrRData_a SHALL be ignored.

Structure
REQ-032 Package accum_pkg SHALL hold the state enum typedef, DEPTH_DEFAULT=1000 and the 64-bit word typedef.
REQ-033 One sub-module, accum_addr_ctr (a counter with clear, increment and a terminal flag at DEPTH-1), SHALL be used; everything else SHALL stay in accum_loader.

Verification
REQ-034 start with init_i=0 and init_acc=5, then stream 1000 words of value 1 with in_last on word 999 -> 1000 writes at addresses 0..999, one r_enable pulse, done_count=1000, and done_valid after w_enable.
REQ-035 Stream 1003 words with no in_last -> only 1000 accepted, in_ready=0 after address 999, and 3 words left pending.
REQ-036 in_last on word 10 with ZEROFILL_EN -> zero writes to addresses 10..999 and done_count=10; without the macro -> KICK the cycle after the last transfer.
REQ-037 in_valid toggling 1/0 every cycle -> writes only on valid cycles and contiguous addresses.
REQ-038 start during WAIT with init_acc=9 -> ignored, and init_acc output unchanged.
REQ-039 rst asserted in WAIT -> next cycle IDLE, all outputs at reset values, no done_valid; a new start then completes normally.
